// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: accepts a word on valid/ready and shifts it out one bit per BIT_CYCLES clocks.
// Optional even-parity trailer bit is compiled in with `define BIT_SERIALIZER_PARITY_EN.
module bit_serializer #(
    parameter int   DATA_W     = 8,
    parameter int   BIT_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter bit   MSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cyc_cnt;
    logic [BW-1:0]     bit_cnt;

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            ready_out <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= IDLE_LEVEL;
`ifdef BIT_SERIALIZER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (valid_in) begin
                        state     <= SHIFT;
                        shreg     <= data_in;
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        ready_out <= 1'b0;
                        busy      <= 1'b1;
                        data_out  <= MSB_FIRST ? data_in[DATA_W-1] : data_in[0];
`ifdef BIT_SERIALIZER_PARITY_EN
                        par       <= ^data_in;
`endif
                    end else begin
                        ready_out <= 1'b1;
                        busy      <= 1'b0;
                        data_out  <= IDLE_LEVEL;
                    end
                end
                SHIFT: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                            state    <= PARITY;
                            data_out <= par;
`else
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            data_out <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // The next bit is already known, so present it on the same edge as the shift.
                            if (MSB_FIRST) begin
                                shreg    <= {shreg[DATA_W-2:0], 1'b0};
                                data_out <= shreg[DATA_W-2];
                            end else begin
                                shreg    <= {1'b0, shreg[DATA_W-1:1]};
                                data_out <= shreg[1];
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt  <= '0;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        data_out <= IDLE_LEVEL;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    ready_out <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    data_out  <= IDLE_LEVEL;
                end
                default: begin
                    state     <= IDLE;
                    cyc_cnt   <= '0;
                    bit_cnt   <= '0;
                    ready_out <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    data_out  <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: table-driven MSB-first vectors plus back-to-back, abort and stretched LSB-first sequences.
// Parity expectations follow `define BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int W  = 8;
    localparam int WT = W + PB;

    logic       clk = 1'b0;
    logic       reset_a, valid_a, ready_a, out_a, busy_a, done_a;
    logic [7:0] data_a;
    logic       reset_b, valid_b, ready_b, out_b, busy_b, done_b;
    logic [7:0] data_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset_a), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .data_out(out_a), .busy(busy_a), .done(done_a)
    );

    bit_serializer #(.DATA_W(8), .BIT_CYCLES(3), .IDLE_LEVEL(1'b0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .data_out(out_b), .busy(busy_b), .done(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] d);
        reset_a = r;
        valid_a = v;
        data_a  = d;
        step();
    endtask

    task automatic add_row(input logic r, input logic v, input logic [7:0] d, input logic [3:0] e);
        vec_t x;
        x.rst   = r;
        x.valid = v;
        x.data  = d;
        x.exp   = e;
        tbl.push_back(x);
    endtask

    // Expected nibble is {ready, busy, done, data_out}; data_in is inverted after acceptance to prove it is ignored.
    task automatic add_word(input logic [7:0] w);
        add_row(1'b1, 1'b1, w, {3'b010, w[7]});
        for (int i = 6; i >= 0; i--) add_row(1'b1, 1'b0, ~w, {3'b010, w[i]});
        if (PB != 0) add_row(1'b1, 1'b0, ~w, {3'b010, ^w});
        add_row(1'b1, 1'b0, ~w, 4'b0010);
        add_row(1'b1, 1'b0, ~w, 4'b1000);
    endtask

    function automatic logic [3:0] exp_b2b(input int c);
        int         k = c / (WT + 2);
        int         p = c % (WT + 2);
        logic [7:0] w = (k == 0) ? 8'h0F : 8'hF0;
        if (p < W)       return {3'b010, w[7-p]};
        else if (p < WT) return {3'b010, ^w};
        else if (p == WT) return 4'b0010;
        else             return 4'b1000;
    endfunction

    initial begin
        int         done_cnt;
        int         n;
        logic [3:0] cb;
        logic [3:0] e;

        reset_a = 1'b0; valid_a = 1'b0; data_a = 8'h00;
        reset_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;

        add_row(1'b0, 1'b1, 8'hFF, 4'b1000);
        add_row(1'b0, 1'b1, 8'hFF, 4'b1000);
        add_word(8'hA5);
        add_word(8'h07);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i].rst, tbl[i].valid, tbl[i].data);
            check_output($sformatf("vec%0d", i), {28'd0, ready_a, busy_a, done_a, out_a}, {28'd0, tbl[i].exp});
        end

        // Back-to-back words with valid held high.
        reset_a = 1'b1; valid_a = 1'b1; data_a = 8'h0F;
        step();
        data_a   = 8'hF0;
        done_cnt = 0;
        n        = 2 * (WT + 2) - 1;
        for (int c = 0; c <= n; c++) begin
            check_output($sformatf("b2b_c%0d", c), {28'd0, ready_a, busy_a, done_a, out_a}, {28'd0, exp_b2b(c)});
            done_cnt += int'(done_a);
            if (c == n - 1) valid_a = 1'b0;
            if (c < n) step();
        end
        check_output("b2b_done_count", done_cnt, 2);

        // Reset during a word aborts it without a done pulse.
        valid_a = 1'b1; data_a = 8'hC3;
        step();
        valid_a = 1'b0;
        cb = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("abort_bit%0d", i), {28'd0, ready_a, busy_a, done_a, out_a}, {28'd0, 3'b010, cb[3-i]});
            if (i < 3) step();
        end
        reset_a = 1'b0;
        step();
        check_output("abort_reset", {28'd0, ready_a, busy_a, done_a, out_a}, 32'h8);
        reset_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_output($sformatf("abort_idle%0d", i), {28'd0, ready_a, busy_a, done_a, out_a}, 32'h8);
        end

        // Stretched LSB-first instance.
        check_output("b_reset", {28'd0, ready_b, busy_b, done_b, out_b}, 32'h8);
        reset_b = 1'b1; valid_b = 1'b1; data_b = 8'h01;
        step();
        valid_b = 1'b0; data_b = 8'hFF;
        for (int c = 0; c <= WT * 3; c++) begin
            if (c < 3)           e = 4'b0101;
            else if (c < 24)     e = 4'b0100;
            else if (c < WT * 3) e = 4'b0101;
            else                 e = 4'b0010;
            check_output($sformatf("b_c%0d", c), {28'd0, ready_b, busy_b, done_b, out_b}, {28'd0, e});
            step();
        end
        check_output("b_idle", {28'd0, ready_b, busy_b, done_b, out_b}, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial transmitter. It accepts a DATA_W-bit word over a valid/ready handshake and drives it one bit at a time onto a single-bit serial line. This is the stimulus end of the team's single-bit-input Moore sequence FSMs: its data_out feeds their data_in. The controller is a Moore FSM with a bit-period counter, a bit counter and a shift register.

Parameters:
DATA_W, 8, word width in bits (>=2)
BIT_CYCLES, 1, clock cycles each serial bit is held (>=1)
IDLE_LEVEL, 0, serial line level when no word is being sent
MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on rising clk)
data_in  input  DATA_W  parallel word to send
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a word this cycle
data_out  output  1  serial bit stream
busy  output  1  word in flight (SHIFT or PARITY state)
done  output  1  one-cycle pulse after the last bit of a word

Behaviour:
- One clock domain. Reset is synchronous and active-low: on a rising clk edge with reset==0, state<=IDLE and counters<=0.
- All outputs are Moore-decoded from the state register and shift register. No output depends combinationally on valid_in or data_in.
- Reset values, in effect after the first reset edge: ready_out=1, busy=0, done=0, data_out=IDLE_LEVEL.
- States are IDLE, SHIFT, PARITY (optional feature only) and DONE. Illegal encodings go to IDLE.
- IDLE:
  - ready_out=1, data_out=IDLE_LEVEL.
  - On an edge with valid_in=1: capture data_in into the shift register, clear bit_cnt and cyc_cnt, and go to SHIFT.
  - valid_in=0 keeps the block in IDLE.
- SHIFT:
  - busy=1, ready_out=0.
  - data_out = shreg[DATA_W-1] when MSB_FIRST=1, otherwise shreg[0].
  - cyc_cnt counts 0..BIT_CYCLES-1. When it wraps, shift shreg one place and increment bit_cnt.
  - When the period of bit DATA_W-1 completes, go to DONE (or to PARITY when the optional feature is compiled in).
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, ready_out=0, data_out=IDLE_LEVEL.
  - Then go to IDLE.
- Latency: the first data bit appears on data_out in the cycle immediately after the accepting edge.
  - A word occupies DATA_W*BIT_CYCLES cycles, plus 1 cycle of DONE.
  - Minimum spacing between accepting edges is DATA_W*BIT_CYCLES+2 cycles.
- data_in and valid_in are ignored outside IDLE. Changing data_in after acceptance does not affect the word in flight.
- Counter widths: cyc_cnt is $clog2(BIT_CYCLES+1) bits, bit_cnt is $clog2(DATA_W+1) bits. Both wrap only under control of the FSM; no free-running overflow.
- Reset mid-word: at the next edge the word is aborted, with no done pulse and no residual bits. The following cycle shows reset values.
- valid_in held high continuously: words are sent back-to-back, each separated by one DONE cycle and one IDLE cycle.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined: after the last data bit the FSM enters PARITY for BIT_CYCLES cycles.
  - data_out = even parity (XOR of all DATA_W bits of the captured word). busy=1 during PARITY.
  - PARITY then goes to DONE. Word time becomes (DATA_W+1)*BIT_CYCLES.
- Undefined: no PARITY state exists. SHIFT goes directly to DONE.

Test Plan:
- Reset: hold reset=0 for 2 edges while valid_in=1 and data_in=8'hFF -> ready_out=1, busy=0, done=0, data_out=0, no transfer starts.
- Basic send (BIT_CYCLES=1, MSB_FIRST=1): send 8'hA5 -> data_out over cycles 1..8 = 1,0,1,0,0,1,0,1; done=1 in cycle 9; ready_out=1 in cycle 10.
- LSB first with stretched bits (MSB_FIRST=0, BIT_CYCLES=3): send 8'h01 -> data_out=1 for 3 cycles, then 0 for 21 cycles, then a single done pulse.
- Back-to-back: valid_in held at 1 with 8'h0F then 8'hF0 -> second accept 2 cycles after the first word's last bit; stream 00001111, then gap, then 11110000; exactly two done pulses.
- Abort: reset=0 asserted after the 3rd bit of 8'hC3 -> next cycle data_out=IDLE_LEVEL, busy=0, ready_out=1, no done pulse.
- Parity (BIT_SERIALIZER_PARITY_EN defined): 8'hA5 -> 9th bit=0; 8'h07 -> 9th bit=1; done in cycle 10.
